// File: rtl/mdu_ex.sv
// mdu_ex -- EX-stage multiply/divide unit with the architectural HI/LO registers.
//
// mult/multu/div/divu latch their 64-bit result into a shadow register at the
// accepting edge. The unit then stays busy for a fixed MULT_CYCLES/DIV_CYCLES
// period and commits the shadow to HI/LO on the last busy edge. mthi/mtlo write
// HI or LO directly in a single edge and never raise busy. Division by zero runs
// the full busy period and then leaves HI/LO untouched.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset (priority over everything)
//   start  in   EX-stage instruction is an MDU op
//   op     in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a      in   rs operand (forwarded)
//   b      in   rt operand (forwarded)
//   busy   out  operation in progress; HI/LO not yet updated
//   hi     out  HI register
//   lo     out  LO register
module mdu_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       shadow_q, shadow_d;
    logic              dbz_q, dbz_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    // ------------------------------------------------------------------
    // Arithmetic on the operands presented at the accepting edge
    // ------------------------------------------------------------------
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_nz;
    logic signed [32:0] a_s33, b_s33, quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic        [63:0] op_result;
    logic               unused_div_msbs;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the divider never sees x/0; the
    // result is discarded anyway via the div_by_zero flag.
    assign b_nz  = (b == 32'd0) ? 32'd1 : b;

    // Signed divide is done at 33 bits so 0x80000000 / -1 yields +2^31,
    // whose low 32 bits are the architecturally required 0x80000000.
    assign a_s33 = {a[31], a};
    assign b_s33 = {b_nz[31], b_nz};
    assign quo_s = a_s33 / b_s33;
    assign rem_s = a_s33 % b_s33;
    assign quo_u = a / b_nz;
    assign rem_u = a % b_nz;

    assign unused_div_msbs = quo_s[32] ^ rem_s[32];

    always_comb begin
        op_result = 64'd0;
        case (op)
            OP_MULT:  op_result = prod_s;
            OP_MULTU: op_result = prod_u;
            OP_DIV:   op_result = {rem_s[31:0], quo_s[31:0]};
            OP_DIVU:  op_result = {rem_u, quo_u};
            default:  op_result = 64'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            shadow_d = op_result;
                            dbz_d    = 1'b0;
                            cnt_d    = MULT_LOAD;
                            state_d  = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            shadow_d = op_result;
                            dbz_d    = (b == 32'd0);
                            cnt_d    = DIV_LOAD;
                            state_d  = S_RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // start is deliberately ignored here: the hazard unit stalls
                // the pipeline while busy, so nothing may restart or write HI/LO.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    if (!dbz_q) begin
                        hi_d = shadow_q[63:32];
                        lo_d = shadow_q[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The shadow is only consumed in RUN, which reset leaves, so it needs no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex -- self-checking bench for mdu_ex: a directed vector table, a few
// hand-written multi-cycle sequences (reset mid-operation, start under busy,
// back-to-back issue) and randomized operations against an arithmetic model.
module tb_mdu_ex;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ex #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs[14];

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Architectural meaning of each op, written with plain 64-bit arithmetic.
    task automatic model_apply(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'd0, ma};
        ub = {32'd0, mb};
        case (mop)
            3'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            3'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd3: if (mb != 0) begin
                sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0];
            end
            3'd4: if (mb != 0) begin
                uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0];
            end
            3'd5: m_hi = ma;
            3'd6: m_lo = ma;
            default: ;
        endcase
    endtask

    function automatic int model_busy(input logic [2:0] mop);
        if (mop == 3'd1 || mop == 3'd2) return MULT_CYCLES;
        if (mop == 3'd3 || mop == 3'd4) return DIV_CYCLES;
        return 0;
    endfunction

    // Present one op for a single edge, then count the sampled busy cycles
    // until busy drops (bounded).
    task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                         output int nbusy);
        start = 1'b1; op = iop; a = ia; b = ib;
        step();
        start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    initial begin
        int nb;
        int eb;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        errors = 0;
        checks = 0;
        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd5, 32'h11111111, 32'd0,        32'h11111111, 32'h80000000, 0};
        vecs[6]  = '{3'd6, 32'h22222222, 32'd0,        32'h11111111, 32'h22222222, 0};
        vecs[7]  = '{3'd3, 32'd5,        32'd0,        32'h11111111, 32'h22222222, 10};
        vecs[8]  = '{3'd4, 32'd9,        32'd0,        32'h11111111, 32'h22222222, 10};
        vecs[9]  = '{3'd0, 32'h33333333, 32'd1,        32'h11111111, 32'h22222222, 0};
        vecs[10] = '{3'd7, 32'h44444444, 32'd1,        32'h11111111, 32'h22222222, 0};
        vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[12] = '{3'd4, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 10};
        vecs[13] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        // Reset state
        do_reset();
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", {31'd0, busy}, 32'd0);

        // Directed table
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            model_apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check_int($sformatf("vec%0d_busy", i), nb, vecs[i].exp_busy);
            check32($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check32($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Start under busy is ignored
        do_reset();
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        step();
        start = 1'b0;
        check32("ign_busy_c1", {31'd0, busy}, 32'd1);
        step();
        start = 1'b1; op = 3'd5; a = 32'h0000DEAD; b = 32'd0;
        step();
        start = 1'b0; op = 3'd0; a = 32'd0;
        nb = 2;
        while (busy && nb < 100) begin
            nb++;
            step();
        end
        check_int("ign_busy_len", nb, MULT_CYCLES);
        check32("ign_hi", hi, 32'd0);
        check32("ign_lo", lo, 32'd12);

        // Back-to-back: divu issued in the first cycle busy is low
        issue(3'd1, 32'd3, 32'd4, nb);
        check_int("b2b_mult_busy", nb, MULT_CYCLES);
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0; op = 3'd0;
        check32("b2b_accept", {31'd0, busy}, 32'd1);
        nb = 1;
        step();
        while (busy && nb < 100) begin
            nb++;
            step();
        end
        check_int("b2b_div_busy", nb, DIV_CYCLES);
        check32("b2b_hi", hi, 32'd2);
        check32("b2b_lo", lo, 32'd14);

        // Reset mid-divide at busy cycle 3 discards the pending result
        issue(3'd5, 32'hAAAAAAAA, 32'd0, nb);
        issue(3'd6, 32'hBBBBBBBB, 32'd0, nb);
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0; op = 3'd0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check32("rst_mid_busy", {31'd0, busy}, 32'd0);
        check32("rst_mid_hi", hi, 32'd0);
        check32("rst_mid_lo", lo, 32'd0);
        for (int k = 0; k < 12; k++) step();
        check32("rst_mid_late_hi", hi, 32'd0);
        check32("rst_mid_late_lo", lo, 32'd0);

        // Reset on the completion edge wins over the commit
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        step();
        start = 1'b0; op = 3'd0;
        for (int k = 1; k < MULT_CYCLES; k++) step();
        check32("rst_cmpl_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check32("rst_cmpl_busy", {31'd0, busy}, 32'd0);
        check32("rst_cmpl_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Randomized ops against the model
        for (int r = 0; r < 60; r++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            start = $urandom_range(0, 4) != 0;
            eb = start ? model_busy(rop) : 0;
            if (start) model_apply(rop, ra, rb);
            op = rop; a = ra; b = rb;
            step();
            start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
            nb = 0;
            while (busy && nb < 100) begin
                nb++;
                step();
            end
            check_int($sformatf("rnd%0d_busy", r), nb, eb);
            check32($sformatf("rnd%0d_hi", r), hi, m_hi);
            check32($sformatf("rnd%0d_lo", r), lo, m_lo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
